// File: rtl/ras_stack_if.sv
// rtl/ras_stack_if.sv - push/pop/status bundle between the RAS controller and stack storage
interface ras_stack_if #(
  parameter int XLEN = 32,
  parameter int PTRW = 3
);
  logic            ras_valid;
  logic            push;
  logic            pop;
  logic            flush;
  logic [XLEN-1:0] pctoras;
  logic [XLEN-1:0] pcfromras;
  logic [PTRW:0]   count;
  logic            empty;
  logic            full;
  logic            overflow;
  logic            underflow;

  modport master (
    output ras_valid, push, pop, flush, pctoras,
    input  pcfromras, count, empty, full, overflow, underflow
  );

  modport slave (
    input  ras_valid, push, pop, flush, pctoras,
    output pcfromras, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return address stack with occupancy and sticky status
// The top-of-stack read path uses registered state only.
// Memory contents are not reset; count gates what is visible.
module ras_stack #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 8,
  parameter int              PTRW      = 3,
  parameter logic [XLEN-1:0] EMPTY_VAL = '0,
  parameter logic [XLEN-1:0] SENTINEL  = '1
) (
  input logic       clk,
  input logic       reset_n,
  ras_stack_if.slave bus
);

  localparam logic [PTRW:0] LP_DEPTH = (PTRW+1)'(DEPTH);

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [PTRW-1:0] r_tos;
  logic [PTRW:0]   r_count;
  logic            r_ovf;
  logic            r_unf;

  logic [PTRW-1:0] w_tos_nxt;
  logic [PTRW:0]   w_count_nxt;
  logic            w_ovf_nxt;
  logic            w_unf_nxt;
  logic            w_we;
  logic [PTRW-1:0] w_waddr;
  logic            w_push;
  logic            w_pop;
  logic            w_flush;

  // A sentinel address means the controller is not really pushing.
  assign w_push  = bus.ras_valid & bus.push & (bus.pctoras != SENTINEL);
  assign w_pop   = bus.ras_valid & bus.pop;
  assign w_flush = bus.ras_valid & bus.flush;

  // Next-state selection: flush, then replace-top, then push, then pop.
  always_comb begin
    w_tos_nxt   = r_tos;
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;
    w_unf_nxt   = r_unf;
    w_we        = 1'b0;
    w_waddr     = r_tos;
    if (w_flush) begin
      w_tos_nxt   = '0;
      w_count_nxt = '0;
      w_ovf_nxt   = 1'b0;
      w_unf_nxt   = 1'b0;
    end else if (w_push && w_pop && (r_count != '0)) begin
      w_we    = 1'b1;
      w_waddr = r_tos;
    end else if (w_push) begin
      // Also covers push&pop on an empty stack, which acts as a plain push.
      w_tos_nxt = r_tos + 1'b1;
      w_we      = 1'b1;
      w_waddr   = r_tos + 1'b1;
      if (r_count == LP_DEPTH) begin
        w_ovf_nxt = 1'b1;
      end else begin
        w_count_nxt = r_count + 1'b1;
      end
    end else if (w_pop) begin
      if (r_count != '0) begin
        w_tos_nxt   = r_tos - 1'b1;
        w_count_nxt = r_count - 1'b1;
      end else begin
        w_unf_nxt = 1'b1;
      end
    end
  end

  // Pointer, occupancy and sticky flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tos   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_tos   <= w_tos_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  // Entry storage; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (reset_n && w_we) begin
      r_mem[w_waddr] <= bus.pctoras;
    end
  end

  assign bus.pcfromras = (r_count == '0) ? EMPTY_VAL : r_mem[r_tos];
  assign bus.count     = r_count;
  assign bus.empty     = (r_count == '0);
  assign bus.full      = (r_count == LP_DEPTH);
  assign bus.overflow  = r_ovf;
  assign bus.underflow = r_unf;

endmodule

// File: tb/tb_ras_stack.sv
// tb/tb_ras_stack.sv - scoreboard bench for ras_stack
module tb_ras_stack;

  localparam logic [31:0] EMPTY_VAL = 32'h0000_0000;
  localparam logic [31:0] SENTINEL  = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic reset_n;

  ras_stack_if #(.XLEN(32), .PTRW(3)) bus ();

  ras_stack #(
    .XLEN(32), .DEPTH(8), .PTRW(3),
    .EMPTY_VAL(EMPTY_VAL), .SENTINEL(SENTINEL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [3:0]  c;
    logic [31:0] pc;
    logic        o;
    logic        u;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_state(input string nm, input int ec, input logic [31:0] ep,
                              input logic eo, input logic eu);
    exp_t e;
    e.nm = nm; e.c = 4'(ec); e.pc = ep; e.o = eo; e.u = eu;
    q.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.ras_valid = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
    bus.flush = 1'b0; bus.pctoras = SENTINEL;
  endtask

  task automatic op(input string nm, input logic v, input logic pu, input logic po,
                    input logic fl, input logic [31:0] pc, input int ec,
                    input logic [31:0] ep, input logic eo, input logic eu);
    @(negedge clk);
    bus.ras_valid = v; bus.push = pu; bus.pop = po; bus.flush = fl; bus.pctoras = pc;
    @(posedge clk);
    #1;
    expect_state(nm, ec, ep, eo, eu);
    idle_inputs();
  endtask

  // Monitor: outputs depend only on registered state, so compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.nm, " count"},     32'(bus.count),     32'(e.c));
        chk({e.nm, " pcfromras"}, bus.pcfromras,      e.pc);
        chk({e.nm, " empty"},     32'(bus.empty),     32'(e.c == 4'd0));
        chk({e.nm, " full"},      32'(bus.full),      32'(e.c == 4'd8));
        chk({e.nm, " overflow"},  32'(bus.overflow),  32'(e.o));
        chk({e.nm, " underflow"}, 32'(bus.underflow), 32'(e.u));
      end
    end
  end

  initial begin
    int budget;
    reset_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    expect_state("reset", 0, EMPTY_VAL, 1'b0, 1'b0);
    @(negedge clk);
    #2 reset_n = 1'b1;

    // Basic LIFO order
    op("t1_push100", 1, 1, 0, 0, 32'h100, 1, 32'h100, 0, 0);
    op("t1_push200", 1, 1, 0, 0, 32'h200, 2, 32'h200, 0, 0);
    op("t1_push300", 1, 1, 0, 0, 32'h300, 3, 32'h300, 0, 0);
    op("t1_pop1",    1, 0, 1, 0, 32'h0,   2, 32'h200, 0, 0);
    op("t1_pop2",    1, 0, 1, 0, 32'h0,   1, 32'h100, 0, 0);
    op("t1_pop3",    1, 0, 1, 0, 32'h0,   0, EMPTY_VAL, 0, 0);

    // Overflow: ninth push overwrites 0x10
    for (int i = 1; i <= 9; i++)
      op($sformatf("t2_push%0d", i), 1, 1, 0, 0, 32'(i * 16),
         (i <= 8) ? i : 8, 32'(i * 16), (i == 9), 0);
    for (int k = 1; k <= 8; k++)
      op($sformatf("t2_pop%0d", k), 1, 0, 1, 0, 32'h0, 8 - k,
         (k < 8) ? 32'(32'h90 - k * 16) : EMPTY_VAL, 1, 0);

    // Underflow, then flush clears both sticky flags
    op("t3_pop_empty", 1, 0, 1, 0, 32'h0, 0, EMPTY_VAL, 1, 1);
    op("t3_flush",     1, 0, 0, 1, 32'h0, 0, EMPTY_VAL, 0, 0);

    // Replace top
    op("t4_pushA0",    1, 1, 0, 0, 32'hA0, 1, 32'hA0, 0, 0);
    op("t4_pushB0",    1, 1, 0, 0, 32'hB0, 2, 32'hB0, 0, 0);
    op("t4_replaceC0", 1, 1, 1, 0, 32'hC0, 2, 32'hC0, 0, 0);
    op("t4_pop",       1, 0, 1, 0, 32'h0,  1, 32'hA0, 0, 0);

    // Sentinel, gating, flush priority, push&pop on empty
    op("t5_sentinel",  1, 1, 0, 0, SENTINEL, 1, 32'hA0, 0, 0);
    op("t5_novalid",   0, 1, 0, 0, 32'h55,   1, 32'hA0, 0, 0);
    op("t5_novalid_fl",0, 0, 0, 1, 32'h0,    1, 32'hA0, 0, 0);
    op("t5_flushpush", 1, 1, 0, 1, 32'h44,   0, EMPTY_VAL, 0, 0);
    op("t5_pop_empty", 1, 0, 1, 0, 32'h0,    0, EMPTY_VAL, 0, 1);
    op("t5_pushpop0",  1, 1, 1, 0, 32'h77,   1, 32'h77, 0, 1);

    // Fill to 5, then async reset while pushing
    op("t6_push1", 1, 1, 0, 0, 32'h1, 2, 32'h1, 0, 1);
    op("t6_push2", 1, 1, 0, 0, 32'h2, 3, 32'h2, 0, 1);
    op("t6_push3", 1, 1, 0, 0, 32'h3, 4, 32'h3, 0, 1);
    op("t6_push4", 1, 1, 0, 0, 32'h4, 5, 32'h4, 0, 1);
    @(negedge clk);
    bus.ras_valid = 1'b1; bus.push = 1'b1; bus.pctoras = 32'h99;
    #2 reset_n = 1'b0;
    #1;
    expect_state("t6_async_reset", 0, EMPTY_VAL, 0, 0);
    @(negedge clk);
    #1 idle_inputs();
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    expect_state("t6_after_release", 0, EMPTY_VAL, 0, 0);

    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
